// File: rtl/cp0_regs.sv
// rtl/cp0_regs.sv - Coprocessor-0 register file, exception state and Count/Compare timer
//
// Purpose: holds BadVAddr, Count, Compare, Status, Cause and EPC. Applies the
// committed exception from the MEM stage, services ERET and MTC0, runs the
// half-rate Count timer and raises an interrupt request for the control unit.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   ex_int[5:0]          level-sensitive hardware interrupt lines
//   exc_valid/code/bd    committed exception, its ExcCode and delay-slot flag
//   exc_pc, exc_badvaddr faulting PC and faulting address
//   exc_bv_we            load BadVAddr with this exception
//   eret                 ERET committing this cycle
//   mtc0_we, cp0_addr,   MTC0 write strobe, register number, write data
//   cp0_wdata
//   cp0_rdata            MFC0 read data (combinational from registered state)
//   epc_out, status_exl  current EPC and Status.EXL
//   int_req              enabled interrupt pending

module cp0_regs (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  ex_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_bv_we,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        status_exl,
  output logic        int_req
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] epc;
  logic [7:0]  status_im;
  logic        exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;   // IP[15:10], sampled from ex_int/TI each cycle
  logic [1:0]  cause_ip_sw;   // IP[9:8], software interrupts
  logic [4:0]  cause_exc;
  logic        tick;          // Count advances on every other cycle

  logic        mtc0_ok;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [7:0]  cause_ip;
  logic [31:0] status_word;
  logic [31:0] cause_word;

  // An exception or ERET in the same cycle suppresses the MTC0 completely.
  assign mtc0_ok    = mtc0_we & ~exc_valid & ~eret;
  assign wr_count   = mtc0_ok & (cp0_addr == ADDR_COUNT);
  assign wr_compare = mtc0_ok & (cp0_addr == ADDR_COMPARE);
  assign wr_status  = mtc0_ok & (cp0_addr == ADDR_STATUS);
  assign wr_cause   = mtc0_ok & (cp0_addr == ADDR_CAUSE);
  assign wr_epc     = mtc0_ok & (cp0_addr == ADDR_EPC);

  assign cause_ip    = {cause_ip_hw, cause_ip_sw};
  assign status_word = {9'b0, 1'b1, 6'b0, status_im, 6'b0, exl, status_ie};
  assign cause_word  = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_exc, 2'b0};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr    <= 32'h0;
      count       <= 32'h0;
      compare     <= 32'h0;
      epc         <= 32'h0;
      status_im   <= 8'h0;
      exl         <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ti    <= 1'b0;
      cause_ip_hw <= 6'h0;
      cause_ip_sw <= 2'h0;
      cause_exc   <= 5'h0;
      tick        <= 1'b0;
    end else begin
      tick <= ~tick;

      // A Count write replaces the increment for that cycle.
      if (wr_count)
        count <= cp0_wdata;
      else if (tick)
        count <= count + 32'd1;

      if (wr_compare)
        compare <= cp0_wdata;

      // Writing Compare acknowledges the timer and beats a coincident match.
      if (wr_compare)
        cause_ti <= 1'b0;
      else if (count == compare)
        cause_ti <= 1'b1;

      // The timer shares IP7 with ex_int[5].
      cause_ip_hw <= {ex_int[5] | cause_ti, ex_int[4:0]};

      if (exc_valid) begin
        // Nested exceptions keep the original return point.
        if (!exl) begin
          epc      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          cause_bd <= exc_bd;
        end
        exl       <= 1'b1;
        cause_exc <= exc_code;
        if (exc_bv_we)
          badvaddr <= exc_badvaddr;
      end else if (eret) begin
        exl <= 1'b0;
      end else begin
        if (wr_status) begin
          status_im <= cp0_wdata[15:8];
          exl       <= cp0_wdata[1];
          status_ie <= cp0_wdata[0];
        end
        if (wr_cause)
          cause_ip_sw <= cp0_wdata[9:8];
        if (wr_epc)
          epc <= cp0_wdata;
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_COMPARE:  cp0_rdata = compare;
      ADDR_STATUS:   cp0_rdata = status_word;
      ADDR_CAUSE:    cp0_rdata = cause_word;
      ADDR_EPC:      cp0_rdata = epc;
      default:       cp0_rdata = 32'h0;
    endcase
  end

  assign epc_out    = epc;
  assign status_exl = exl;
  assign int_req    = status_ie & ~exl & (|(cause_ip & status_im));

endmodule
